// File: rtl/display_control_if.sv
// Signal bundle between the bike computer's measurement/timekeeping blocks,
// the display controller and the LCD segment driver.
interface display_control_if;
  logic        half_sec_pulse;
  logic        sec_pulse;
  logic        mode;
  logic [6:0]  max_speed;
  logic [6:0]  speed;
  logic [13:0] distance;
  logic [9:0]  avg_speed;
  logic [18:0] HMS_time;

  logic        DAY;
  logic        AVS;
  logic        MAX;
  logic        TIM;
  logic        col;
  logic        point;
  logic [7:0]  lower1000;
  logic [7:0]  lower0100;
  logic [7:0]  lower0010;
  logic [7:0]  lower0001;
  logic [7:0]  upper10;
  logic [7:0]  upper01;

  modport slave (
    input  half_sec_pulse, sec_pulse, mode, max_speed, speed, distance, avg_speed, HMS_time,
    output DAY, AVS, MAX, TIM, col, point,
    output lower1000, lower0100, lower0010, lower0001, upper10, upper01
  );

  modport master (
    output half_sec_pulse, sec_pulse, mode, max_speed, speed, distance, avg_speed, HMS_time,
    input  DAY, AVS, MAX, TIM, col, point,
    input  lower1000, lower0100, lower0010, lower0001, upper10, upper01
  );
endinterface

// File: rtl/display_control.sv
// Bike computer display controller: mode FSM, saturation, BCD conversion and
// 7-segment encoding for the 2-digit speed field and the 4-digit lower field.
module display_control (
  input  logic          clock,
  input  logic          reset,
  display_control_if.slave bus
);

  typedef enum logic [1:0] {
    S_DAY = 2'd0,
    S_AVS = 2'd1,
    S_MAX = 2'd2,
    S_TIM = 2'd3
  } state_e;

  typedef struct packed {
    logic       day;
    logic       avs;
    logic       max;
    logic       tim;
    logic       col;
    logic       point;
    logic [7:0] l1000;
    logic [7:0] l0100;
    logic [7:0] l0010;
    logic [7:0] l0001;
    logic [7:0] u10;
    logic [7:0] u01;
  } disp_t;

  localparam disp_t DISP_RESET = '{day: 1'b1, default: '0};

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'h3F;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5B;
      4'd3:    seg7 = 8'h4F;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6D;
      4'd6:    seg7 = 8'h7D;
      4'd7:    seg7 = 8'h07;
      4'd8:    seg7 = 8'h7F;
      4'd9:    seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

  // Shift-add-3 conversion of a value below 1_000_000 into six BCD digits.
  function automatic logic [23:0] bin2bcd(input logic [19:0] v);
    logic [23:0] bcd;
    bcd = '0;
    for (int i = 19; i >= 0; i--) begin
      for (int n = 0; n < 6; n++) begin
        if (bcd[n*4 +: 4] >= 4'd5) bcd[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
      end
      bcd = {bcd[22:0], v[i]};
    end
    return bcd;
  endfunction

  state_e      r_state;
  logic        r_mode_d;
  disp_t       r_disp;

  state_e      w_next_state;
  logic        w_press;
  disp_t       w_disp;

  logic [6:0]  w_spd_sat;
  logic [13:0] w_dist_sat;
  logic [9:0]  w_avg_sat;
  logic [6:0]  w_max_sat;
  logic [6:0]  w_hrs_sat;
  logic [5:0]  w_min_sat;
  logic [5:0]  w_sec_sat;
  logic [13:0] w_tim_val;
  logic [13:0] w_lower_val;
  logic [19:0] w_bin;
  logic [23:0] w_bcd;

  assign w_press    = bus.mode & ~r_mode_d;

  assign w_spd_sat  = (bus.speed > 7'd99)         ? 7'd99     : bus.speed;
  assign w_dist_sat = (bus.distance > 14'd9999)   ? 14'd9999  : bus.distance;
  assign w_avg_sat  = (bus.avg_speed > 10'd999)   ? 10'd999   : bus.avg_speed;
  assign w_max_sat  = (bus.max_speed > 7'd99)     ? 7'd99     : bus.max_speed;
  assign w_hrs_sat  = (bus.HMS_time[18:12] > 7'd99) ? 7'd99   : bus.HMS_time[18:12];
  assign w_min_sat  = (bus.HMS_time[11:6] > 6'd59)  ? 6'd59   : bus.HMS_time[11:6];
  assign w_sec_sat  = (bus.HMS_time[5:0] > 6'd59)   ? 6'd59   : bus.HMS_time[5:0];

  // Two 2-digit time fields are packed as left*100+right so one conversion yields both.
  assign w_tim_val = (w_hrs_sat != 7'd0)
                   ? ({7'd0, w_hrs_sat} * 14'd100 + {8'd0, w_min_sat})
                   : ({8'd0, w_min_sat} * 14'd100 + {8'd0, w_sec_sat});

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    if (w_press) begin
      unique case (r_state)
        S_DAY: w_next_state = S_AVS;
        S_AVS: w_next_state = S_MAX;
        S_MAX: w_next_state = S_TIM;
        S_TIM: w_next_state = S_DAY;
      endcase
    end
  end

  always_comb begin
    w_lower_val = w_dist_sat;
    unique case (w_next_state)
      S_DAY: w_lower_val = w_dist_sat;
      S_AVS: w_lower_val = {4'd0, w_avg_sat};
      S_MAX: w_lower_val = {7'd0, w_max_sat};
      S_TIM: w_lower_val = w_tim_val;
    endcase
  end

  // Speed occupies the top two decimal digits, the lower field the bottom four.
  assign w_bin = {13'd0, w_spd_sat} * 20'd10000 + {6'd0, w_lower_val};
  assign w_bcd = bin2bcd(w_bin);

  always_comb begin
    w_disp       = '0;
    w_disp.day   = (w_next_state == S_DAY);
    w_disp.avs   = (w_next_state == S_AVS);
    w_disp.max   = (w_next_state == S_MAX);
    w_disp.tim   = (w_next_state == S_TIM);
    w_disp.u10   = (w_bcd[23:20] == 4'd0) ? 8'h00 : seg7(w_bcd[23:20]);
    w_disp.u01   = seg7(w_bcd[19:16]);
    w_disp.l0001 = seg7(w_bcd[3:0]);
    unique case (w_next_state)
      S_DAY: begin
        w_disp.point = 1'b1;
        w_disp.l1000 = (w_bcd[15:12] == 4'd0) ? 8'h00 : seg7(w_bcd[15:12]);
        w_disp.l0100 = (w_bcd[15:8] == 8'd0)  ? 8'h00 : seg7(w_bcd[11:8]);
        w_disp.l0010 = seg7(w_bcd[7:4]);
      end
      S_AVS: begin
        w_disp.point = 1'b1;
        w_disp.l0100 = (w_bcd[11:8] == 4'd0) ? 8'h00 : seg7(w_bcd[11:8]);
        w_disp.l0010 = seg7(w_bcd[7:4]);
      end
      S_MAX: begin
        w_disp.l0010 = (w_bcd[7:4] == 4'd0) ? 8'h00 : seg7(w_bcd[7:4]);
      end
      S_TIM: begin
        w_disp.l1000 = seg7(w_bcd[15:12]);
        w_disp.l0100 = seg7(w_bcd[11:8]);
        w_disp.l0010 = seg7(w_bcd[7:4]);
      end
    endcase

    // Colon: high on TIM entry, sec_pulse beats half_sec_pulse, otherwise toggle/hold.
    if (w_next_state != S_TIM)   w_disp.col = 1'b0;
    else if (r_state != S_TIM)   w_disp.col = 1'b1;
    else if (bus.sec_pulse)      w_disp.col = 1'b1;
    else if (bus.half_sec_pulse) w_disp.col = ~r_disp.col;
    else                         w_disp.col = r_disp.col;
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    // mode_d follows the button even in reset so a press held across reset is not counted.
    r_mode_d <= bus.mode;
    if (!reset) begin
      r_state <= S_DAY;
      r_disp  <= DISP_RESET;
    end else begin
      r_state <= w_next_state;
      r_disp  <= w_disp;
    end
  end

  assign bus.DAY       = r_disp.day;
  assign bus.AVS       = r_disp.avs;
  assign bus.MAX       = r_disp.max;
  assign bus.TIM       = r_disp.tim;
  assign bus.col       = r_disp.col;
  assign bus.point     = r_disp.point;
  assign bus.lower1000 = r_disp.l1000;
  assign bus.lower0100 = r_disp.l0100;
  assign bus.lower0010 = r_disp.l0010;
  assign bus.lower0001 = r_disp.l0001;
  assign bus.upper10   = r_disp.u10;
  assign bus.upper01   = r_disp.u01;

endmodule

// File: tb/tb_display_control.sv
// Directed self-checking bench for display_control: mode cycling, digit
// encoding, blanking, saturation, colon behaviour and reset with mode held.
module tb_display_control;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  display_control_if bus ();

  display_control u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge before sampling.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press();
    bus.mode = 1'b1;
    tick();
    bus.mode = 1'b0;
    tick();
  endtask

  function automatic logic [3:0] ind();
    return {bus.DAY, bus.AVS, bus.MAX, bus.TIM};
  endfunction

  function automatic logic [31:0] lower();
    return {bus.lower1000, bus.lower0100, bus.lower0010, bus.lower0001};
  endfunction

  function automatic logic [15:0] upper();
    return {bus.upper10, bus.upper01};
  endfunction

  initial begin
    n_checks           = 0;
    n_fail             = 0;
    reset              = 1'b0;
    bus.half_sec_pulse = 1'b0;
    bus.sec_pulse      = 1'b0;
    bus.mode           = 1'b0;
    bus.max_speed      = 7'd0;
    bus.speed          = 7'd69;
    bus.distance       = 14'd1920;
    bus.avg_speed      = 10'd33;
    bus.HMS_time       = 19'd0;
    tick();
    tick();
    check("rst_ind",   ind(),     4'b1000);
    check("rst_lower", lower(),   32'h0);
    check("rst_upper", upper(),   16'h0);
    check("rst_point", bus.point, 1'b0);
    check("rst_col",   bus.col,   1'b0);

    reset = 1'b1;
    tick();
    check("day_ind",   ind(),     4'b1000);
    check("day_upper", upper(),   16'h7D6F);
    check("day_lower", lower(),   32'h066F5B3F);
    check("day_point", bus.point, 1'b1);
    check("day_col",   bus.col,   1'b0);

    bus.mode = 1'b1;
    tick();
    bus.mode = 1'b0;
    check("avs_ind",   ind(),     4'b0100);
    check("avs_lower", lower(),   32'h00004F4F);
    check("avs_point", bus.point, 1'b1);
    tick();
    check("avs_stay",  ind(),     4'b0100);

    bus.max_speed = 7'd50;
    bus.mode      = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    bus.mode = 1'b0;
    tick();
    check("hold_once", ind(),     4'b0010);
    check("max_lower", lower(),   32'h00006D3F);
    check("max_point", bus.point, 1'b0);
    bus.max_speed = 7'd5;
    tick();
    check("max_blank", lower(),   32'h0000006D);

    bus.HMS_time = {7'd0, 6'd1, 6'd5};
    press();
    check("tim_ind",   ind(),     4'b0001);
    check("tim_mmss",  lower(),   32'h3F063F6D);
    check("tim_entry", bus.col,   1'b1);
    check("tim_point", bus.point, 1'b0);

    bus.half_sec_pulse = 1'b1;
    tick();
    check("col_half1", bus.col, 1'b0);
    tick();
    check("col_half2", bus.col, 1'b1);
    tick();
    check("col_half3", bus.col, 1'b0);
    bus.half_sec_pulse = 1'b0;
    tick();
    check("col_hold",  bus.col, 1'b0);
    bus.sec_pulse = 1'b1;
    tick();
    check("col_sec",   bus.col, 1'b1);
    bus.sec_pulse      = 1'b0;
    bus.half_sec_pulse = 1'b1;
    tick();
    check("col_half4", bus.col, 1'b0);
    bus.sec_pulse = 1'b1;
    tick();
    check("col_both",  bus.col, 1'b1);
    bus.sec_pulse      = 1'b0;
    bus.half_sec_pulse = 1'b0;

    bus.HMS_time = {7'd2, 6'd3, 6'd7};
    tick();
    check("tim_hhmm",  lower(), 32'h3F5B3F4F);
    bus.HMS_time = {7'd0, 6'd63, 6'd60};
    tick();
    check("tim_clamp", lower(), 32'h6D6F6D6F);
    bus.HMS_time = {7'd120, 6'd5, 6'd0};
    tick();
    check("tim_hsat",  lower(), 32'h6F6F3F6D);

    press();
    check("wrap_ind",  ind(),     4'b1000);
    check("wrap_col",  bus.col,   1'b0);

    bus.speed    = 7'd120;
    bus.distance = 14'd12000;
    tick();
    check("spd_sat",   upper(),   16'h6F6F);
    check("dist_sat",  lower(),   32'h6F6F6F6F);
    bus.speed    = 7'd5;
    bus.distance = 14'd5;
    tick();
    check("spd_blank", upper(),   16'h006D);
    check("dist_lz",   lower(),   32'h00003F6D);
    bus.speed = 7'd0;
    tick();
    check("spd_zero",  upper(),   16'h003F);

    bus.avg_speed = 10'd1023;
    press();
    check("avg_sat",   lower(),   32'h006F6F6F);
    bus.avg_speed = 10'd5;
    tick();
    check("avg_lz",    lower(),   32'h00003F6D);

    press();
    press();
    check("pre_rst",   ind(),     4'b0001);
    bus.mode = 1'b1;
    reset    = 1'b0;
    tick();
    check("mrst_ind",   ind(),    4'b1000);
    check("mrst_lower", lower(),  32'h0);
    check("mrst_upper", upper(),  16'h0);
    check("mrst_col",   bus.col,  1'b0);
    reset = 1'b1;
    tick();
    tick();
    tick();
    check("held_noadv", ind(),    4'b1000);
    bus.mode = 1'b0;
    tick();
    bus.mode = 1'b1;
    tick();
    bus.mode = 1'b0;
    check("repress",    ind(),    4'b0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
